// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM states and the feedback function used by both the
// pattern generator and the checker so the two sides cannot disagree on the polynomial.
package lfsr_pkg;

  localparam int unsigned LfsrMaxWidth = 32;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StCheck  = 2'd1,
    StLocked = 2'd2
  } lfsr_chk_state_t;

  // Callers zero-extend narrower tap masks and states to LfsrMaxWidth.
  function automatic logic lfsr_feedback(input logic [LfsrMaxWidth-1:0] taps,
                                         input logic [LfsrMaxWidth-1:0] state);
    return ^(taps & state);
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Received-bit history plus next-bit prediction; h[0] always holds the most recent bit.
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] taps,
  output logic             pred
);

  logic [WIDTH-1:0] h_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      h_q <= '0;
    end else if (in_valid) begin
      h_q <= {h_q[WIDTH-2:0], in_bit};
    end
  end

  assign pred = lfsr_feedback(LfsrMaxWidth'(taps), LfsrMaxWidth'(h_q));

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: hunt, check, lock, flag mismatches.
// Define LFSR_CHECKER_ERRCNT_EN to build the saturating error counter; otherwise err_count is 0.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned LOCK_COUNT  = 8,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     taps,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 lock,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state
);

  localparam int unsigned FillW = $clog2(WIDTH + 1);
  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW  = $clog2(LOSS_THRESH + 1);

  lfsr_chk_state_t  state_q;
  logic [FillW-1:0] fill_q;
  logic [GoodW-1:0] good_q;
  logic [BadW-1:0]  bad_q;
  logic             lock_q;
  logic             err_q;
  logic             pred;
  logic             match;
  logic             flush;

  assign flush = rst | clear;
  assign match = (in_bit == pred);

  lfsr_predict #(
    .WIDTH(WIDTH)
  ) u_predict (
    .clk     (clk),
    .flush   (flush),
    .in_valid(in_valid),
    .in_bit  (in_bit),
    .taps    (taps),
    .pred    (pred)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= StHunt;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          StHunt: begin
            if (fill_q == FillW'(WIDTH - 1)) begin
              state_q <= StCheck;
              fill_q  <= '0;
              good_q  <= '0;
            end else begin
              fill_q <= fill_q + FillW'(1);
            end
          end
          StCheck: begin
            if (!match) begin
              good_q <= '0;
            end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
              state_q <= StLocked;
              good_q  <= '0;
              bad_q   <= '0;
              lock_q  <= 1'b1;
            end else begin
              good_q <= good_q + GoodW'(1);
            end
          end
          StLocked: begin
            if (match) begin
              bad_q <= '0;
            end else begin
              // The mismatch that drops lock is still reported.
              err_q <= 1'b1;
              if (bad_q == BadW'(LOSS_THRESH - 1)) begin
                state_q <= StHunt;
                fill_q  <= '0;
                bad_q   <= '0;
                lock_q  <= 1'b0;
              end else begin
                bad_q <= bad_q + BadW'(1);
              end
            end
          end
          default: begin
            state_q <= StHunt;
            lock_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      err_count_q <= '0;
    end else if (in_valid && (state_q == StLocked) && !match && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

  assign lock  = lock_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default instance and a 2-bit-counter instance share stimulus.
module tb_lfsr_checker;

  localparam logic [4:0] Taps = 5'b10100;
`ifdef LFSR_CHECKER_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_bit;
  logic [4:0]  taps;
  logic        lock, err, lock_s, err_s;
  logic [15:0] err_count;
  logic [1:0]  err_count_s;
  logic [1:0]  state, state_s;
  logic [4:0]  gen_s;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .clear(clear), .taps(taps), .in_valid(in_valid), .in_bit(in_bit),
    .lock(lock), .err(err), .err_count(err_count), .state(state)
  );

  lfsr_checker #(.WIDTH(5), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .taps(taps), .in_valid(in_valid), .in_bit(in_bit),
    .lock(lock_s), .err(err_s), .err_count(err_count_s), .state(state_s)
  );

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  // Generator model: emits s[0], then shifts in the feedback bit.
  task automatic gen_bit(output logic b);
    b     = gen_s[0];
    gen_s = {gen_s[3:0], ^(Taps & gen_s)};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++; if (lock !== 1'b0) $display("FAIL reset_lock: got %b expected 0", lock); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL reset_cnt: got %0d expected 0", err_count);
    else passed++;
    checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else passed++;
    checks++; if (err_count_s !== 2'd0) $display("FAIL reset_cnt_sat: got %0d expected 0", err_count_s);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_lock;
    logic b;
    logic err_seen;
    err_seen = 1'b0;
    gen_s = 5'b00001;
    for (int i = 0; i < 100; i++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0);
      if (err === 1'b1) err_seen = 1'b1;
      if (i == 3) begin
        checks++; if (state !== 2'd0) $display("FAIL hunt_state: got %0d expected 0", state);
        else passed++;
      end
      if (i == 4) begin
        checks++; if (state !== 2'd1) $display("FAIL check_state: got %0d expected 1", state);
        else passed++;
      end
      if (i == 11) begin
        checks++; if (lock !== 1'b0) $display("FAIL early_lock: got %b expected 0", lock);
        else passed++;
      end
      if (i == 12) begin
        checks++; if (lock !== 1'b1) $display("FAIL lock_13: got %b expected 1", lock);
        else passed++;
        checks++; if (state !== 2'd2) $display("FAIL locked_state: got %0d expected 2", state);
        else passed++;
      end
    end
    checks++; if (err_seen !== 1'b0) $display("FAIL clean_err: got %b expected 0", err_seen);
    else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL clean_cnt: got %0d expected 0", err_count);
    else passed++;
  endtask

  task automatic test_single_flip;
    logic b;
    logic exp;
    for (int j = 0; j < 20; j++) begin
      gen_bit(b);
      step(1'b1, b ^ (j == 0), 1'b0);
      exp = (j == 0) || (j == 3) || (j == 5);
      checks++; if (err !== exp) $display("FAIL flip_err[%0d]: got %b expected %b", j, err, exp);
      else passed++;
    end
    checks++; if (err_count !== (CntEn ? 16'd3 : 16'd0))
      $display("FAIL flip_cnt: got %0d expected %0d", err_count, CntEn ? 3 : 0);
    else passed++;
    checks++; if (lock !== 1'b1) $display("FAIL flip_lock: got %b expected 1", lock); else passed++;
  endtask

  task automatic test_clear;
    logic b;
    gen_bit(b);
    step(1'b1, b, 1'b1);
    checks++; if (lock !== 1'b0) $display("FAIL clear_lock: got %b expected 0", lock); else passed++;
    checks++; if (err_count !== 16'd0) $display("FAIL clear_cnt: got %0d expected 0", err_count);
    else passed++;
    checks++; if (state !== 2'd0) $display("FAIL clear_state: got %0d expected 0", state);
    else passed++;
    for (int i = 0; i < 13; i++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0);
      if (i == 11) begin
        checks++; if (lock !== 1'b0) $display("FAIL relock_early: got %b expected 0", lock);
        else passed++;
      end
    end
    checks++; if (lock !== 1'b1) $display("FAIL relock: got %b expected 1", lock); else passed++;
  endtask

  task automatic test_saturation;
    logic b;
    int pulses;
    pulses = 0;
    for (int j = 0; j < 25; j++) begin
      gen_bit(b);
      step(1'b1, b ^ ((j == 0) || (j == 10)), 1'b0);
      if (err_s === 1'b1) pulses++;
      if (j == 10) begin
        checks++; if (err_count !== (CntEn ? 16'd4 : 16'd0))
          $display("FAIL sat_mid_cnt: got %0d expected %0d", err_count, CntEn ? 4 : 0);
        else passed++;
        checks++; if (err_count_s !== (CntEn ? 2'd3 : 2'd0))
          $display("FAIL sat_mid_hold: got %0d expected %0d", err_count_s, CntEn ? 3 : 0);
        else passed++;
      end
    end
    checks++; if (pulses != 6) $display("FAIL sat_pulses: got %0d expected 6", pulses); else passed++;
    checks++; if (err_count !== (CntEn ? 16'd6 : 16'd0))
      $display("FAIL sat_cnt: got %0d expected %0d", err_count, CntEn ? 6 : 0);
    else passed++;
    checks++; if (err_count_s !== (CntEn ? 2'd3 : 2'd0))
      $display("FAIL sat_hold: got %0d expected %0d", err_count_s, CntEn ? 3 : 0);
    else passed++;
    checks++; if (lock_s !== 1'b1) $display("FAIL sat_lock: got %b expected 1", lock_s); else passed++;
  endtask

  task automatic test_toggle_valid;
    logic b;
    logic idle_err;
    int nvalid;
    idle_err = 1'b0;
    nvalid = 0;
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    gen_s = 5'b00001;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (cyc % 2 == 0) begin
        gen_bit(b);
        step(1'b1, b, 1'b0);
        nvalid++;
        if (nvalid == 12) begin
          checks++; if (lock !== 1'b0) $display("FAIL toggle_early: got %b expected 0", lock);
          else passed++;
        end
      end else begin
        step(1'b0, 1'b1, 1'b0);
        if (err !== 1'b0) idle_err = 1'b1;
      end
    end
    checks++; if (lock !== 1'b1) $display("FAIL toggle_lock: got %b expected 1", lock); else passed++;
    checks++; if (idle_err !== 1'b0) $display("FAIL idle_err: got %b expected 0", idle_err);
    else passed++;
  endtask

  task automatic test_invert;
    logic b;
    logic exp_err;
    logic exp_lock;
    logic relock;
    relock = 1'b0;
    for (int j = 0; j < 60; j++) begin
      gen_bit(b);
      step(1'b1, ~b, 1'b0);
      // Two taps: mixed history (bits 3, 4) still predicts the inverted bit.
      exp_err  = (j <= 8) && ((j <= 2) || (j >= 5));
      exp_lock = (j < 8);
      if (j < 12) begin
        checks++; if (err !== exp_err)
          $display("FAIL inv_err[%0d]: got %b expected %b", j, err, exp_err);
        else passed++;
        checks++; if (lock !== exp_lock)
          $display("FAIL inv_lock[%0d]: got %b expected %b", j, lock, exp_lock);
        else passed++;
      end
      if (j == 8) begin
        checks++; if (state !== 2'd0) $display("FAIL inv_state: got %0d expected 0", state);
        else passed++;
      end
      if (j >= 12 && lock === 1'b1) relock = 1'b1;
    end
    checks++; if (relock !== 1'b0) $display("FAIL inv_relock: got %b expected 0", relock);
    else passed++;
    checks++; if (state !== 2'd1) $display("FAIL inv_end_state: got %0d expected 1", state);
    else passed++;
    checks++; if (err_count !== (CntEn ? 16'd7 : 16'd0))
      $display("FAIL inv_cnt: got %0d expected %0d", err_count, CntEn ? 7 : 0);
    else passed++;
  endtask

  initial begin
    rst      = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    taps     = Taps;
    gen_s    = 5'b00001;
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_clear();
    test_saturation();
    test_toggle_valid();
    test_invert();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
